// File: rtl/tiny_nn_stream_feeder.sv
// tiny_nn_stream_feeder: packs host bytes into 16-bit words, buffers them in a
// small FIFO and releases each command packet (header + payload) to
// tiny_nn_top as a contiguous burst, driving 0x0000 between packets.
module tiny_nn_stream_feeder #(
   parameter int unsigned Depth = 16,
   parameter int unsigned LenW  = 12
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic [7:0]  byte_i,
   input  logic        byte_valid_i,
   output logic        byte_ready_o,
   output logic [15:0] data_o,
   output logic        busy_o,
   output logic        underrun_o
);

   localparam int unsigned AW = $clog2(Depth);
   localparam int unsigned CW = AW + 1;

   typedef enum logic [1:0] {StIdle, StWait, StStream} state_e;

   logic [15:0]     mem_q [Depth];
   logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]   count_q;
   logic            phase_q;
   logic [7:0]      hi_q;
   state_e          state_q, state_d;
   logic [LenW-1:0] remain_q, remain_d;
   logic            first_q, first_d;
   logic [15:0]     data_q, data_d;
   logic            underrun_q, underrun_d;
   logic            byte_acc;
   logic            push;
   logic            pop;
   logic [15:0]     head;
   logic [31:0]     need;

   assign byte_ready_o = (count_q < CW'(Depth));
   assign byte_acc     = byte_valid_i & byte_ready_o;
   // The second byte of a word completes it and pushes in the same cycle.
   assign push         = byte_acc & phase_q;
   assign head         = mem_q[rd_ptr_q];

   // Words needed before a burst can start: the whole packet, capped at a full FIFO.
   assign need = ((32'(remain_q) + 32'd1) > 32'(Depth)) ? 32'(Depth) : (32'(remain_q) + 32'd1);

   // Byte phase and high-byte holding register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         phase_q <= 1'b0;
         hi_q    <= 8'h00;
      end else if (byte_acc) begin
         phase_q <= ~phase_q;
         if (!phase_q) hi_q <= byte_i;
      end
   end

   // FIFO storage; contents are don't-care while count is zero.
   always_ff @(posedge clk_i) begin
      if (push) mem_q[wr_ptr_q] <= {hi_q, byte_i};
   end

   // FIFO pointers and occupancy.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         case ({push, pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // FSM and output registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= StIdle;
         remain_q   <= '0;
         first_q    <= 1'b0;
         data_q     <= 16'h0000;
         underrun_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         remain_q   <= remain_d;
         first_q    <= first_d;
         data_q     <= data_d;
         underrun_q <= underrun_d;
      end
   end

   // Next-state: wait for the packet to be buffered, then burst it out.
   always_comb begin
      state_d    = state_q;
      remain_d   = remain_q;
      first_d    = first_q;
      data_d     = 16'h0000;
      underrun_d = underrun_q;
      pop        = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (count_q != '0) begin
               remain_d = head[LenW-1:0];
               first_d  = 1'b1;
               state_d  = StWait;
            end
         end
         StWait: begin
            if (32'(count_q) >= need) state_d = StStream;
         end
         StStream: begin
            if (count_q != '0) begin
               pop    = 1'b1;
               data_d = head;
               if (first_q) begin
                  // Header word: no payload consumed yet.
                  first_d = 1'b0;
                  if (remain_q == '0) state_d = StIdle;
               end else begin
                  remain_d = remain_q - LenW'(1);
                  if (remain_q == LenW'(1)) state_d = StIdle;
               end
            end else begin
               // Host fell behind: emit a zero gap, hold remain, flag it.
               underrun_d = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   assign data_o     = data_q;
   assign busy_o     = (state_q != StIdle);
   assign underrun_o = underrun_q;

endmodule

// File: doc/tiny_nn_stream_feeder.md
Name: tiny_nn_stream_feeder

Overview:
Upstream input stage for tiny_nn_top. It accepts bytes from the 8-bit host pin interface and assembles them into 16-bit words. Words are buffered in a small FIFO, and the block releases each command packet (header plus payload) onto tiny_nn_top data_i as a contiguous burst, one word per cycle. Between packets it drives FP zero (0x0000), so the core sees idle/zero input.

Parameters:
Depth, 16, FIFO depth in 16-bit words (power of two, >= 4)
LenW, 12, width of header length field (header = {op[3:0], len[11:0]})

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
byte_i  in  8  host byte, high byte of each word first
byte_valid_i  in  1  byte_i valid this cycle
byte_ready_o  out  1  byte accepted when valid&ready
data_o  out  16  word stream to tiny_nn_top data_i (registered)
busy_o  out  1  high in WAIT or STREAM
underrun_o  out  1  sticky: FIFO empty while payload still owed

Behaviour:
- One clock (clk_i); reset asynchronous, active-low (rst_ni). Reset clears the FIFO, the byte phase, the FSM (to IDLE) and remain. data_o=0x0000, busy_o=0, underrun_o=0. byte_ready_o=1 once FIFO count < Depth.
- Reset asserted mid-packet aborts immediately. No partial word or packet survives.
- Byte assembly: a phase bit toggles on every accepted byte. Phase 0 stores byte_i into hi_q. Phase 1 pushes {hi_q, byte_i} into the FIFO that cycle.
- byte_ready_o = (count < Depth). It is combinational from the registered count and is independent of phase.
- FIFO: count register is 0..Depth, with wrapping read/write pointers. A simultaneous push and pop leaves count unchanged. A push is never attempted when full because ready is low.
- FSM states:
  - IDLE: data_o<=0x0000. If count>0 (head is a header), latch remain<=head.len and go WAIT.
  - WAIT: data_o<=0x0000. When count >= min(remain+1, Depth), go STREAM.
  - STREAM: each cycle with count>0, pop head and load data_o<=head.
    - The first pop is the header word, unmodified.
    - Each subsequent pop decrements remain.
    - When the pop happens with remain==0 (header of a len=0 packet, or last payload word), go IDLE.
- Output latency: a word popped on edge N appears on data_o after edge N. The header reaches data_o exactly one cycle after WAIT->STREAM.
- Packets are separated by at least one 0x0000 cycle: IDLE always emits one zero cycle, then WAIT emits at least one.
- Underrun: in STREAM with count==0, data_o<=0x0000 and remain is held. underrun_o<=1 (sticky until reset). Streaming resumes when data arrives.
- len=0: header alone is a one-word packet.
- len+1 > Depth: streaming starts when FIFO is full. The host must then sustain at least 2 bytes/cycle-equivalent, or underrun is flagged.
- Payload words are not interpreted; bf16 values pass through bit-exact.

Test Plan:
1. Reset: hold rst_ni low mid-clock -> data_o=0x0000, busy_o=0, byte_ready_o=1, underrun_o=0.
2. Single packet: bytes 10 08 then 8×(3F 00), one per cycle -> after the last byte, data_o shows 0x1008 then 8 consecutive 0x3F00, then 0x0000. underrun_o=0.
3. Header-only: bytes 20 00 -> data_o shows one cycle of 0x2000 between zeros. busy_o returns to 0.
4. Long packet: header 0x1020 (len 32), payload 0x0001..0x0020 at 1 byte/cycle, Depth=16.
   - Stream starts at count=16.
   - FIFO drains faster than it fills -> 0x0000 gaps inserted and underrun_o=1.
   - All 32 payload words still appear in order.
5. Back-to-back packets: 0x1002,A,B immediately followed by 0x1001,C -> A,B then at least two 0x0000 cycles, then 0x1001,C.
6. Mid-stream reset: assert rst_ni during payload word 3 -> data_o=0x0000 immediately, and a fresh packet afterward streams correctly.
